// File: rtl/regfile_loader.sv
// Debug byte-stream loader: frames of {hdr, cnt, words} become regfile writes, stalling the core meanwhile.
// Write appears 1 cycle after a word's last byte; done/err follow one cycle later; in_ready drops only in WRITE.
module regfile_loader #(
    parameter int         XLEN    = 32,
    parameter int         NREGS   = 32,
    parameter logic [2:0] HDR_TAG = 3'b101,
    parameter int         TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     rf_we,
    output logic [$clog2(NREGS)-1:0] rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    output logic                     cpu_stall,
    output logic                     done,
    output logic                     err
);
    localparam int IW = $clog2(NREGS);
    localparam int NB = XLEN / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int RW = $clog2(((NREGS > 255) ? NREGS : 255) + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_CNT, S_DATA, S_WRITE} state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [RW-1:0]   remaining;
    logic [BW-1:0]   bcnt;
    logic [TW-1:0]   tcnt;
    logic [XLEN-1:0] word;
    logic [XLEN-1:0] next_word;

    assign in_ready = !rst && (state != S_WRITE);

    always_comb begin
        next_word = word;
        next_word[{bcnt, 3'b000} +: 8] = in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            remaining <= '0;
            bcnt      <= '0;
            tcnt      <= '0;
            word      <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            cpu_stall <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            rf_we <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            // Stall stays up through the done/err cycle; a new header below re-arms it.
            if (done || err) cpu_stall <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (in_data[7:5] == HDR_TAG) begin
                            idx       <= IW'(32'(in_data[4:0]) % NREGS);
                            cpu_stall <= 1'b1;
                            tcnt      <= '0;
                            state     <= S_CNT;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_CNT: begin
                    if (in_valid) begin
                        remaining <= (in_data == 8'd0) ? RW'(NREGS) : RW'(in_data);
                        bcnt      <= '0;
                        tcnt      <= '0;
                        state     <= S_DATA;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        tcnt  <= '0;
                        state <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_DATA: begin
                    if (in_valid) begin
                        tcnt <= '0;
                        if (bcnt == BW'(NB - 1)) begin
                            bcnt     <= '0;
                            word     <= '0;
                            rf_we    <= (idx != '0);
                            rf_waddr <= idx;
                            rf_wdata <= next_word;
                            state    <= S_WRITE;
                        end else begin
                            word <= next_word;
                            bcnt <= bcnt + BW'(1);
                        end
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        // Abort drops the partial word; earlier words are already written.
                        err   <= 1'b1;
                        tcnt  <= '0;
                        bcnt  <= '0;
                        word  <= '0;
                        state <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_WRITE: begin
                    idx       <= (idx == IW'(NREGS - 1)) ? '0 : idx + IW'(1);
                    remaining <= remaining - RW'(1);
                    if (remaining == RW'(1)) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        state <= S_DATA;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_loader.sv
// Bench for regfile_loader: directed frame table, timeout/reset sequences, and randomized frames vs a write-list model.
module tb_regfile_loader;
    localparam int TO = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready, rf_we, cpu_stall, done, err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    regfile_loader #(.XLEN(32), .NREGS(32), .HDR_TAG(3'b101), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .cpu_stall(cpu_stall), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Observed activity, sampled on the falling edge.
    logic [36:0] got_w[$];
    logic [36:0] exp_w[$];
    int cyc = 0, done_cnt = 0, err_cnt = 0, stall_cnt = 0, both_cnt = 0;
    int last_we_cyc = 0, last_done_cyc = 0;
    int gi = 0, ei = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rf_we) begin
            got_w.push_back({rf_waddr, rf_wdata});
            last_we_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (err) err_cnt++;
        if (cpu_stall) stall_cnt++;
        if (done && err) both_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        int guard;
        in_data  = b;
        in_valid = 1'b1;
        ok = 1'b0;
        guard = 0;
        while (!ok && guard < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            guard++;
        end
        #1 in_valid = 1'b0;
        if (!ok) chk("handshake", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends a whole frame and records the register writes it must produce.
    task automatic send_frame(input logic [7:0] hdr, input logic [7:0] cnt,
                              input logic [31:0] wd0, input int maxgap);
        int n, id;
        logic [31:0] w;
        send_byte(hdr);
        if (hdr[7:5] != 3'b101) return;
        idle($urandom_range(maxgap, 0));
        send_byte(cnt);
        n  = (cnt == 8'd0) ? 32 : int'(cnt);
        id = int'(hdr[4:0]);
        for (int i = 0; i < n; i++) begin
            w = (i == 0 && wd0 != 32'd0) ? wd0 : $urandom;
            for (int b = 0; b < 4; b++) begin
                idle($urandom_range(maxgap, 0));
                send_byte(w[8*b +: 8]);
            end
            if (id != 0) exp_w.push_back({5'(id), w});
            id = (id + 1) % 32;
        end
    endtask

    task automatic check_writes(input string name);
        int ng, ne;
        ng = got_w.size() - gi;
        ne = exp_w.size() - ei;
        chk({name, "_nwrites"}, 64'(ng), 64'(ne));
        for (int i = 0; i < ng && i < ne; i++) begin
            chk({name, "_waddr"}, 64'(got_w[gi + i][36:32]), 64'(exp_w[ei + i][36:32]));
            chk({name, "_wdata"}, 64'(got_w[gi + i][31:0]), 64'(exp_w[ei + i][31:0]));
        end
        gi = got_w.size();
        ei = exp_w.size();
    endtask

    typedef struct {
        logic [7:0]  hdr;
        logic [7:0]  cnt;
        logic [31:0] wd0;
        int          nwe;
        int          ndone;
        int          nerr;
        int          nstall;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int d0, e0, s0, w0, nbad;
        logic [2:0] t;
        logic [31:0] w;

        tbl[0] = '{8'hA1, 8'h01, 32'h12345678, 1, 1, 0, 7};
        tbl[1] = '{8'hA0, 8'h02, 32'h0, 1, 1, 0, 12};
        tbl[2] = '{8'hBF, 8'h03, 32'h0, 2, 1, 0, 17};
        tbl[3] = '{8'h41, 8'h00, 32'h0, 0, 0, 1, 0};
        tbl[4] = '{8'hA3, 8'h00, 32'h0, 31, 1, 0, 162};
        tbl[5] = '{8'hA1, 8'h22, 32'h0, 33, 1, 0, 172};

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_stall", 64'(cpu_stall), 64'd0);
        chk("rst_outs", 64'({rf_we, done, err}), 64'd0);
        chk("rst_waddr_wdata", 64'({rf_waddr, rf_wdata}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Directed frames
        for (int k = 0; k < 6; k++) begin
            d0 = done_cnt; e0 = err_cnt; s0 = stall_cnt; w0 = got_w.size();
            send_frame(tbl[k].hdr, tbl[k].cnt, tbl[k].wd0, 0);
            idle(4);
            chk($sformatf("tbl%0d_nwe", k), 64'(got_w.size() - w0), 64'(tbl[k].nwe));
            chk($sformatf("tbl%0d_done", k), 64'(done_cnt - d0), 64'(tbl[k].ndone));
            chk($sformatf("tbl%0d_err", k), 64'(err_cnt - e0), 64'(tbl[k].nerr));
            chk($sformatf("tbl%0d_stall_cycles", k), 64'(stall_cnt - s0), 64'(tbl[k].nstall));
            @(negedge clk);
            chk($sformatf("tbl%0d_in_ready", k), 64'(in_ready), 64'd1);
            check_writes($sformatf("tbl%0d", k));
            if (k == 0) chk("done_lag", 64'(last_done_cyc - last_we_cyc), 64'd1);
            idle(1);
        end

        // Timeout after one complete word and a partial one
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hA5);
        send_byte(8'h02);
        w = $urandom;
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
        exp_w.push_back({5'd5, w});
        send_byte(8'hEE);
        send_byte(8'hDD);
        idle(TO + 4);
        chk("to_err", 64'(err_cnt - e0), 64'd1);
        chk("to_done", 64'(done_cnt - d0), 64'd0);
        @(negedge clk);
        chk("to_stall", 64'(cpu_stall), 64'd0);
        check_writes("to");
        idle(1);

        // An idle gap of TIMEOUT-1 cycles must not abort
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hA6);
        send_byte(8'h01);
        w = $urandom;
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        idle(TO - 1);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
        exp_w.push_back({5'd6, w});
        idle(4);
        chk("near_to_err", 64'(err_cnt - e0), 64'd0);
        chk("near_to_done", 64'(done_cnt - d0), 64'd1);
        check_writes("near_to");

        // Reset in the middle of a word
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hA2);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_stall", 64'(cpu_stall), 64'd0);
        chk("mid_rst_outs", 64'({rf_we, done, err}), 64'd0);
        chk("mid_rst_waddr_wdata", 64'({rf_waddr, rf_wdata}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(3);
        chk("mid_rst_done", 64'(done_cnt - d0), 64'd0);
        chk("mid_rst_err", 64'(err_cnt - e0), 64'd0);
        check_writes("mid_rst");
        send_frame(8'hA2, 8'h01, 32'h0, 0);
        idle(4);
        chk("post_rst_done", 64'(done_cnt - d0), 64'd1);
        check_writes("post_rst");

        // Randomized frames with gaps and occasional bad headers
        d0 = done_cnt; e0 = err_cnt; nbad = 0;
        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(5, 0) == 0) begin
                t = 3'($urandom_range(6, 0));
                if (t >= 3'd5) t = t + 3'd1;
                send_byte({t, 5'($urandom)});
                nbad++;
            end else begin
                send_frame({3'b101, 5'($urandom)}, 8'($urandom_range(4, 1)), 32'h0, 3);
            end
            idle($urandom_range(3, 0));
        end
        idle(5);
        chk("rand_done", 64'(done_cnt - d0), 64'(30 - nbad));
        chk("rand_err", 64'(err_cnt - e0), 64'(nbad));
        check_writes("rand");
        chk("done_err_exclusive", 64'(both_cnt), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
